note_sequencer: RTL and testbench
=================================

# note_sequencer

Record/playback sequencer for the 64×32 note RAM. It receives beat ticks from the tempo divider and, per tick, either writes the current 32-bit fret/string note word into the RAM (record) or reads the next stored word and hands it to the audio module over a valid/ready handshake (play). It owns the RAM address, write-enable and recorded song length, replacing ad-hoc address counting in the guitar datapath.

## Interface
- No parameters; depth fixed at 64 words, width 32.
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- beat_tick  in  1  one-cycle pulse per beat from the tempo divider
- start_rec  in  1  one-cycle command: begin recording at address 0
- start_play  in  1  one-cycle command: begin playback at address 0
- stop  in  1  one-cycle command: abort the current operation
- note_in  in  32  note word from the coordinates converter
- ram_q  in  32  RAM read data, valid one cycle after ram_addr
- note_ready  in  1  audio module accepts note_out
- ram_addr  out  6  RAM address
- ram_wren  out  1  RAM write enable
- ram_data  out  32  RAM write data
- note_out  out  32  played note word
- note_valid  out  1  note_out valid
- song_len  out  7  stored note count, 0..64
- late  out  1  sticky: a beat arrived while a note was still unaccepted
- busy  out  1  high in any state other than IDLE
- state  out  3  current state encoding, for LEDs

## Operation
- States: IDLE=0, REC=1, PLAY_REQ=2, PLAY_WAIT=3, PLAY_OUT=4.
- Command priority: stop > start_rec > start_play. Commands other than stop are ignored unless in IDLE.
- IDLE, start_rec: idx←0, song_len←0, late unchanged, go to REC.
- REC, beat_tick: next cycle ram_wren=1, ram_addr=idx, ram_data=note_in sampled on the tick cycle; idx←idx+1; song_len←song_len+1. After the 64th write (song_len=64): return to IDLE automatically.
- REC, stop: return to IDLE; song_len keeps the count already written. A tick coinciding with stop is not written.
- IDLE, start_play: if song_len=0, remain in IDLE. Otherwise idx←0, clear late, go to PLAY_REQ.
- PLAY_REQ, beat_tick: drive ram_addr=idx and go to PLAY_WAIT.
- PLAY_WAIT: capture ram_q into note_out, assert note_valid, go to PLAY_OUT.
- PLAY_OUT: hold note_out and note_valid until note_ready. On acceptance: idx←idx+1. If idx+1=song_len, go to IDLE; otherwise go to PLAY_REQ.
- PLAY_OUT, beat_tick while note_valid&&!note_ready: set late. The tick is discarded.
- stop in any PLAY state: note_valid drops the next cycle and the state returns to IDLE.
- ram_wren is 0 in every state except the single write cycle in REC. ram_data=note_in register. ram_addr=idx.
- idx is 6 bits and wraps 63→0 only under the loop option.

## Timing
- All outputs registered.
- Reset values: ram_addr=0, ram_wren=0, ram_data=0, note_out=0, note_valid=0, song_len=0, late=0, busy=0, state=IDLE.
- Record latency: tick at cycle T produces the write at T+1.
- Play latency: tick at T gives ram_addr at T+1, ram_q at T+2, note_valid high from T+3.
- Handshake: transfer occurs on a cycle with note_valid&&note_ready. note_out is stable while note_valid=1 and the transfer has not occurred.
- A stop asserted on the same cycle as a handshake: the transfer completes, then the state returns to IDLE.
- Assertion of resetn mid-operation clears everything immediately, including song_len. RAM contents are not cleared.

## Configuration
- NOTE_SEQ_LOOP_EN defined: on acceptance of the last note (idx+1=song_len), idx←0 and the state goes to PLAY_REQ. Playback repeats until stop.
- NOTE_SEQ_LOOP_EN undefined: playback ends in IDLE after the last note, as described in Operation.

## Test plan
- Record 5 ticks, note_in=0x1,0x2,...,0x5, then stop -> writes to addr 0..4 with matching data, one cycle after each tick; song_len=5; state=IDLE.
- Play after that recording, note_ready held at 1 -> note_out sequence 0x1..0x5, each note_valid 3 cycles after its tick; IDLE after the 5th; late=0.
- Play with note_ready=0 across two ticks -> note_out held stable; late=1; no address advance until ready.
- Record 70 ticks -> exactly 64 writes (addr 0..63); song_len=64; automatic IDLE; ticks 65..70 cause no ram_wren.
- start_play with song_len=0, and start_rec+stop in the same cycle -> state stays IDLE, busy=0, no RAM activity.
- With NOTE_SEQ_LOOP_EN and song_len=3 -> notes at idx 0,1,2,0,1... until stop. Reset mid-play -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback sequencer for the 64x32 note RAM.
// Latency: record tick T -> RAM write at T+1; play tick T -> ram_addr T+1, note_valid T+3.
// Backpressure: note_out is held until note_ready; beats arriving meanwhile set the sticky late flag.
// Option: define NOTE_SEQ_LOOP_EN to restart playback at the first note after the last one.
module note_sequencer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        beat_tick,
   input  logic        start_rec,
   input  logic        start_play,
   input  logic        stop,
   input  logic [31:0] note_in,
   input  logic [31:0] ram_q,
   input  logic        note_ready,
   output logic [5:0]  ram_addr,
   output logic        ram_wren,
   output logic [31:0] ram_data,
   output logic [31:0] note_out,
   output logic        note_valid,
   output logic [6:0]  song_len,
   output logic        late,
   output logic        busy,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REC       = 3'd1,
      S_PLAY_REQ  = 3'd2,
      S_PLAY_WAIT = 3'd3,
      S_PLAY_OUT  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic        rd_wait_q, rd_wait_d;
   logic [5:0]  ram_addr_q, ram_addr_d;
   logic        ram_wren_q, ram_wren_d;
   logic [31:0] ram_data_q, ram_data_d;
   logic [31:0] note_out_q, note_out_d;
   logic        note_valid_q, note_valid_d;
   logic [6:0]  song_len_q, song_len_d;
   logic        late_q, late_d;
   logic        busy_q, busy_d;
   logic        last_note;

   // Next-state and next-output logic; commands are ranked stop > start_rec > start_play
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rd_wait_d    = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wren_d   = 1'b0;
      ram_data_d   = ram_data_q;
      note_out_d   = note_out_q;
      note_valid_d = note_valid_q;
      song_len_d   = song_len_q;
      late_d       = late_q;
      last_note    = (({1'b0, idx_q} + 7'd1) == song_len_q);

      unique case (state_q)
         S_IDLE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (start_rec) begin
               idx_d      = 6'd0;
               ram_addr_d = 6'd0;
               song_len_d = 7'd0;
               state_d    = S_REC;
            end else if (start_play && (song_len_q != 7'd0)) begin
               idx_d      = 6'd0;
               ram_addr_d = 6'd0;
               late_d     = 1'b0;
               state_d    = S_PLAY_REQ;
            end
         end

         S_REC: begin
            if (stop) begin
               // a tick on the stop cycle is dropped on purpose
               state_d = S_IDLE;
            end else if (beat_tick) begin
               ram_wren_d = 1'b1;
               ram_addr_d = idx_q;
               ram_data_d = note_in;
               song_len_d = song_len_q + 7'd1;
               if (song_len_q == 7'd63) begin
                  // RAM full: keep idx at 63 rather than wrapping
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end

         S_PLAY_REQ: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (beat_tick) begin
               ram_addr_d = idx_q;
               state_d    = S_PLAY_WAIT;
            end
         end

         S_PLAY_WAIT: begin
            // first cycle presents the address, second cycle sees ram_q
            if (stop) begin
               state_d = S_IDLE;
            end else if (!rd_wait_q) begin
               rd_wait_d = 1'b1;
            end else begin
               note_out_d   = ram_q;
               note_valid_d = 1'b1;
               state_d      = S_PLAY_OUT;
            end
         end

         S_PLAY_OUT: begin
            if (note_valid_q && note_ready) begin
               note_valid_d = 1'b0;
               if (last_note) begin
`ifdef NOTE_SEQ_LOOP_EN
                  idx_d   = 6'd0;
                  state_d = S_PLAY_REQ;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  idx_d   = idx_q + 6'd1;
                  state_d = S_PLAY_REQ;
               end
               // the transfer still counts when stop lands on it
               if (stop) begin
                  state_d = S_IDLE;
               end
            end else if (stop) begin
               note_valid_d = 1'b0;
               state_d      = S_IDLE;
            end else if (beat_tick) begin
               late_d = 1'b1;
            end
         end

         default: begin
            note_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Single register bank for FSM state and all outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         idx_q        <= 6'd0;
         rd_wait_q    <= 1'b0;
         ram_addr_q   <= 6'd0;
         ram_wren_q   <= 1'b0;
         ram_data_q   <= 32'd0;
         note_out_q   <= 32'd0;
         note_valid_q <= 1'b0;
         song_len_q   <= 7'd0;
         late_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rd_wait_q    <= rd_wait_d;
         ram_addr_q   <= ram_addr_d;
         ram_wren_q   <= ram_wren_d;
         ram_data_q   <= ram_data_d;
         note_out_q   <= note_out_d;
         note_valid_q <= note_valid_d;
         song_len_q   <= song_len_d;
         late_q       <= late_d;
         busy_q       <= busy_d;
      end
   end

   assign ram_addr   = ram_addr_q;
   assign ram_wren   = ram_wren_q;
   assign ram_data   = ram_data_q;
   assign note_out   = note_out_q;
   assign note_valid = note_valid_q;
   assign song_len   = song_len_q;
   assign late       = late_q;
   assign busy       = busy_q;
   assign state      = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: command table, hand-written record/play sequences,
// and randomized record/playback compared against a queue-based song model.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        beat_tick = 1'b0, start_rec = 1'b0, start_play = 1'b0, stop = 1'b0;
   logic        note_ready = 1'b0;
   logic [31:0] note_in = 32'd0;
   logic [31:0] ram_q;
   logic [5:0]  ram_addr;
   logic        ram_wren;
   logic [31:0] ram_data, note_out;
   logic        note_valid, late, busy;
   logic [6:0]  song_len;
   logic [2:0]  state;

   note_sequencer dut (
      .clk(clk), .resetn(resetn), .beat_tick(beat_tick), .start_rec(start_rec),
      .start_play(start_play), .stop(stop), .note_in(note_in), .ram_q(ram_q),
      .note_ready(note_ready), .ram_addr(ram_addr), .ram_wren(ram_wren),
      .ram_data(ram_data), .note_out(note_out), .note_valid(note_valid),
      .song_len(song_len), .late(late), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   // synchronous 64x32 RAM: read data one cycle after the address
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   typedef struct { logic [5:0] addr; logic [31:0] data; int cyc; } wr_t;
   typedef struct { logic [31:0] data; int cyc; } xf_t;
   typedef struct { logic rec; logic ply; logic stp; logic [2:0] exp_state; logic exp_busy; } vec_t;

   wr_t         wr_log[$];
   xf_t         xf_log[$];
   int          tick_log[$];
   logic [31:0] rec_q[$];
   int          n_chk = 0, n_pass = 0;
   int          cyc = 0;
   int          unstable = 0;
   bit          exp_late = 0;
   logic        hold_vld = 1'b0;
   logic [31:0] hold_dat = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // one clock cycle: drive inputs, log what the DUT shows this cycle, advance
   task automatic step(input logic tk, input logic rec, input logic ply, input logic stp,
                       input logic rdy, input logic [31:0] nin);
      wr_t w;
      xf_t x;
      beat_tick = tk; start_rec = rec; start_play = ply; stop = stp;
      note_ready = rdy; note_in = nin;
      if (resetn) begin
         if (ram_wren) begin
            w.addr = ram_addr; w.data = ram_data; w.cyc = cyc;
            wr_log.push_back(w);
         end
         if (note_valid && rdy) begin
            x.data = note_out; x.cyc = cyc;
            xf_log.push_back(x);
         end
         if (note_valid && !rdy && tk) exp_late = 1;
         if (hold_vld && note_valid && (note_out !== hold_dat)) unstable++;
         hold_vld = note_valid && !rdy;
         hold_dat = note_out;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 32'hDEAD_BEEF);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      beat_tick = 1'b0; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0; note_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b1;
      hold_vld = 1'b0;
   endtask

   task automatic chk_rst(input string p);
      chk($sformatf("%s ram_addr", p), 32'(ram_addr), 32'd0);
      chk($sformatf("%s ram_wren", p), 32'(ram_wren), 32'd0);
      chk($sformatf("%s ram_data", p), ram_data, 32'd0);
      chk($sformatf("%s note_out", p), note_out, 32'd0);
      chk($sformatf("%s note_valid", p), 32'(note_valid), 32'd0);
      chk($sformatf("%s song_len", p), 32'(song_len), 32'd0);
      chk($sformatf("%s late", p), 32'(late), 32'd0);
      chk($sformatf("%s busy", p), 32'(busy), 32'd0);
      chk($sformatf("%s state", p), 32'(state), 32'd0);
   endtask

   // record every word in rec_q, one tick each, then stop
   task automatic record(input bit rnd_gap);
      tick_log.delete();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      foreach (rec_q[i]) begin
         tick_log.push_back(cyc);
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rec_q[i]);
         idle(rnd_gap ? $urandom_range(0, 2) : 2, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      idle(1, 1'b0);
   endtask

   // start playback and give n ticks spaced gap cycles apart, ready held at rdy
   task automatic play(input int n, input int gap, input logic rdy);
      tick_log.delete();
      xf_log.delete();
      step(1'b0, 1'b0, 1'b1, 1'b0, rdy, 32'd0);
      for (int i = 0; i < n; i++) begin
         tick_log.push_back(cyc);
         step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 32'd0);
         idle(gap - 1, rdy);
      end
   endtask

   vec_t vt[7];

   initial begin
      int bad;
      int n;

      // reset state
      #12;
      chk_rst("reset");
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(2, 1'b0);

      // command table from IDLE with an empty song
      vt[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
      vt[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
      vt[3] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1};
      vt[4] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
      vt[6] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         step(1'b0, vt[i].rec, vt[i].ply, vt[i].stp, 1'b0, 32'd0);
         chk($sformatf("cmd%0d state", i), 32'(state), 32'(vt[i].exp_state));
         chk($sformatf("cmd%0d busy", i), 32'(busy), 32'(vt[i].exp_busy));
         chk($sformatf("cmd%0d wren", i), 32'(ram_wren), 32'd0);
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      end
      chk("cmd song_len", 32'(song_len), 32'd0);

      // record five notes, then stop
      wr_log.delete();
      rec_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
      record(1'b0);
      chk("rec5 writes", wr_log.size(), 5);
      for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
         chk($sformatf("rec5 addr%0d", i), 32'(wr_log[i].addr), i);
         chk($sformatf("rec5 data%0d", i), wr_log[i].data, i + 1);
         chk($sformatf("rec5 lat%0d", i), wr_log[i].cyc, tick_log[i] + 1);
      end
      chk("rec5 song_len", 32'(song_len), 32'd5);
      chk("rec5 state", 32'(state), 32'd0);

      // play it back with ready held high
      play(5, 6, 1'b1);
      idle(3, 1'b1);
      chk("play5 count", xf_log.size(), 5);
      for (int i = 0; i < 5 && i < xf_log.size(); i++) begin
         chk($sformatf("play5 note%0d", i), xf_log[i].data, i + 1);
         chk($sformatf("play5 lat%0d", i), xf_log[i].cyc, tick_log[i] + 3);
      end
      chk("play5 state", 32'(state), 32'd0);
      chk("play5 late", 32'(late), 32'd0);

      // play with ready low across two beats
      play(1, 1, 1'b0);
      for (int k = 0; k < 10 && !note_valid; k++) idle(1, 1'b0);
      chk("stall valid", 32'(note_valid), 32'd1);
      chk("stall first note", note_out, 32'h1);
      unstable = 0;
      for (int k = 0; k < 8; k++) step((k == 2 || k == 5), 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("stall late", 32'(late), 32'd1);
      chk("stall addr", 32'(ram_addr), 32'd0);
      chk("stall still valid", 32'(note_valid), 32'd1);
      chk("stall stable", unstable, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      chk("stall xfer", xf_log.size(), 1);
      if (xf_log.size() > 0) chk("stall xfer data", xf_log[0].data, 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      chk("stall stop state", 32'(state), 32'd0);
      chk("stall stop valid", 32'(note_valid), 32'd0);

      // record 70 ticks: only the first 64 land
      wr_log.delete();
      rec_q.delete();
      for (int i = 0; i < 70; i++) rec_q.push_back(32'h100 + i);
      record(1'b0);
      chk("rec70 writes", wr_log.size(), 64);
      bad = 0;
      foreach (wr_log[i]) if (wr_log[i].addr != 6'(i) || wr_log[i].data != 32'h100 + i) bad++;
      chk("rec70 content", bad, 0);
      chk("rec70 song_len", 32'(song_len), 32'd64);
      chk("rec70 state", 32'(state), 32'd0);

      // empty-song play and start_rec+stop leave everything idle
      do_reset();
      wr_log.delete();
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("empty play state", 32'(state), 32'd0);
      chk("empty play busy", 32'(busy), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      chk("rec+stop state", 32'(state), 32'd0);
      chk("rec+stop busy", 32'(busy), 32'd0);
      idle(3, 1'b0);
      chk("idle no writes", wr_log.size(), 0);

      // randomized record/playback against the song model
      for (int r = 0; r < 4; r++) begin
         rec_q.delete();
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) rec_q.push_back($urandom);
         record(1'b1);
         chk($sformatf("rnd%0d song_len", r), 32'(song_len), n);
         xf_log.delete();
         exp_late = 0;
         unstable = 0;
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
         for (int k = 0; k < 3000 && state != 3'd0; k++)
            step(($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 32'd0);
         chk($sformatf("rnd%0d done", r), 32'(state), 32'd0);
         chk($sformatf("rnd%0d count", r), xf_log.size(), n);
         bad = 0;
         foreach (xf_log[i]) if (i >= n || xf_log[i].data !== rec_q[i]) bad++;
         chk($sformatf("rnd%0d notes", r), bad, 0);
         chk($sformatf("rnd%0d late", r), 32'(late), 32'(exp_late));
         chk($sformatf("rnd%0d stable", r), unstable, 0);
      end

`ifdef NOTE_SEQ_LOOP_EN
      // looping playback of a three-note song
      do_reset();
      rec_q = '{32'hA, 32'hB, 32'hC};
      record(1'b0);
      play(8, 6, 1'b1);
      chk("loop count", xf_log.size(), 8);
      bad = 0;
      foreach (xf_log[i]) if (xf_log[i].data != rec_q[i % 3]) bad++;
      chk("loop order", bad, 0);
      chk("loop busy", 32'(busy), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      chk("loop stop", 32'(state), 32'd0);
`endif

      // reset in the middle of playback clears outputs at once
      rec_q = '{32'h77, 32'h88};
      record(1'b0);
      play(1, 1, 1'b0);
      for (int k = 0; k < 10 && !note_valid; k++) idle(1, 1'b0);
      chk("midplay valid", 32'(note_valid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk_rst("midplay reset");
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(2, 1'b0);
      chk("post reset state", 32'(state), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
